// File: rtl/input_port_pkg.sv
// input_port_pkg: shared CPU widths and debounce defaults for the input port.
package input_port_pkg;
   localparam int DATA_W = 4;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
   function automatic int cntWidth(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction
endpackage

// File: rtl/input_port_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus counter-based debouncer for one switch bit.
module debounce_bit import input_port_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic clr_n,
   input  logic swIn,
   output logic stable,
   output logic busy
);
   localparam int CW = cntWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic s1, s2, flip;
   logic [CW-1:0] cnt, nextCnt;
   always_comb begin
      flip = (s2 != stable) && (cnt == LAST);
      nextCnt = ((s2 == stable) || flip) ? '0 : cnt + 1'b1;
   end
   // busy looks at the next count so settling is registered in step with cnt
   assign busy = nextCnt != '0;
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         cnt <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= swIn;
         s2 <= s1;
         cnt <= nextCnt;
         stable <= flip ? s2 : stable;
      end
endmodule

// File: rtl/input_port.sv
// input_port: debounced switch port presenting changes to the input register with a load strobe.
module input_port import input_port_pkg::*; #(
   parameter int WIDTH = DATA_W,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             hold,
   output logic [WIDTH-1:0] data_out,
   output logic             load,
   output logic             settling
);
   logic [WIDTH-1:0] stableBits, busyBits;
   logic present;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
         .clk(clk), .clr_n(clr_n), .swIn(sw_in[i]),
         .stable(stableBits[i]), .busy(busyBits[i])
      );
   end
   assign present = !hold && (stableBits != data_out);
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         data_out <= '0;
         load <= 1'b0;
         settling <= 1'b0;
      end else begin
         load <= present;
         data_out <= present ? stableBits : data_out;
         settling <= |busyBits;
      end
endmodule
